// File: rtl/instr_reg_ctrl.sv
// ============================================================================
// instr_reg_ctrl : round-robin write arbiter plus in-order reader for a shared
//                  instruction register file, with occupancy tracking.
// Revision 1.0
// ============================================================================
`default_nettype none

module instr_reg_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5,
  parameter int OP_W    = 32,
  parameter int OPC_W   = 4,
  parameter int INSTR_W = OPC_W + 2 * OP_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*OP_W-1:0]    req_op_a,
  input  logic [NUM_REQ*OP_W-1:0]    req_op_b,
  input  logic [NUM_REQ*OPC_W-1:0]   req_opc,
  output logic                       load_en,
  output logic [OP_W-1:0]            operand_a,
  output logic [OP_W-1:0]            operand_b,
  output logic [OPC_W-1:0]           opcode,
  output logic [ADDR_W-1:0]          write_pointer,
  output logic [ADDR_W-1:0]          read_pointer,
  input  logic [INSTR_W-1:0]         instr_word_in,
  input  logic                       rd_req,
  output logic                       rd_valid,
  output logic [INSTR_W-1:0]         rd_data,
  output logic [ADDR_W:0]            count,
  output logic                       full,
  output logic                       empty
);

  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [RR_W-1:0]   RR_ONE  = 1;
  localparam logic [RR_W-1:0]   RR_LAST = RR_W'(NUM_REQ - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_TOP = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   CNT_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    CAP  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [RR_W-1:0]   rr_ptr;
  logic [RR_W-1:0]   grant_idx;
  logic              grant_found;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              accept_wr, accept_rd, do_flush;
  logic [OP_W-1:0]   sel_op_a, sel_op_b;
  logic [OPC_W-1:0]  sel_opc;

  function automatic logic [RR_W-1:0] rr_index(input logic [RR_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return RR_W'(s);
  endfunction

  // First valid requester at or after rr_ptr, wrapping around
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && req_valid[rr_index(rr_ptr, k)]) begin
        grant_found = 1'b1;
        grant_idx   = rr_index(rr_ptr, k);
      end
    end
  end

  always_comb begin
    sel_op_a = req_op_a[int'(grant_idx) * OP_W +: OP_W];
    sel_op_b = req_op_b[int'(grant_idx) * OP_W +: OP_W];
    sel_opc  = req_opc[int'(grant_idx) * OPC_W +: OPC_W];
  end

  assign full  = (count == CNT_MAX);
  assign empty = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
    do_flush  = 1'b0;
    load_en   = 1'b0;
    case (state)
      IDLE: begin
        if (flush) begin
          do_flush = 1'b1;
        end else if (rd_req && !empty) begin
          accept_rd = 1'b1;
          state_nxt = RD;
        end else if (grant_found && !full) begin
          accept_wr            = 1'b1;
          req_ready[grant_idx] = 1'b1;
          state_nxt            = WR;
        end
      end
      WR: begin
        load_en   = 1'b1;
        state_nxt = IDLE;
      end
      RD:      state_nxt = CAP;
      CAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reads and writes are serialised by the FSM, so count never moves both ways at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      opcode        <= '0;
      write_pointer <= '0;
      read_pointer  <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (do_flush) begin
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        count         <= '0;
        write_pointer <= '0;
        read_pointer  <= '0;
      end
      if (accept_rd) read_pointer <= rd_ptr;
      if (accept_wr) begin
        operand_a     <= sel_op_a;
        operand_b     <= sel_op_b;
        opcode        <= sel_opc;
        write_pointer <= wr_ptr;
        rr_ptr        <= (grant_idx == RR_LAST) ? '0 : grant_idx + RR_ONE;
      end
      if (state == WR) begin
        wr_ptr <= (wr_ptr == PTR_TOP) ? '0 : wr_ptr + PTR_ONE;
        count  <= count + CNT_ONE;
      end
      if (state == CAP) begin
        rd_data  <= instr_word_in;
        rd_valid <= 1'b1;
        rd_ptr   <= (rd_ptr == PTR_TOP) ? '0 : rd_ptr + PTR_ONE;
        count    <= count - CNT_ONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_reg_ctrl.sv
// ============================================================================
// tb_instr_reg_ctrl : scoreboard bench for instr_reg_ctrl with a queue model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_instr_reg_ctrl;

  localparam int NR = 4;
  localparam int DP = 32;
  localparam int AW = 5;
  localparam int OW = 32;
  localparam int CW = 4;
  localparam int IW = CW + 2 * OW;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*OW-1:0] req_op_a, req_op_b;
  logic [NR*CW-1:0] req_opc;
  logic            load_en;
  logic [OW-1:0]   operand_a, operand_b;
  logic [CW-1:0]   opcode;
  logic [AW-1:0]   write_pointer, read_pointer;
  logic [IW-1:0]   instr_word_in;
  logic            rd_req = 1'b0;
  logic            rd_valid;
  logic [IW-1:0]   rd_data;
  logic [AW:0]     count;
  logic            full, empty;

  logic [OW-1:0] da [NR];
  logic [OW-1:0] db [NR];
  logic [CW-1:0] dc [NR];
  logic [IW-1:0] mem [DP];

  instr_reg_ctrl #(.NUM_REQ(NR), .DEPTH(DP), .ADDR_W(AW), .OP_W(OW), .OPC_W(CW), .INSTR_W(IW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op_a(req_op_a), .req_op_b(req_op_b), .req_opc(req_opc),
    .load_en(load_en), .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode),
    .write_pointer(write_pointer), .read_pointer(read_pointer),
    .instr_word_in(instr_word_in), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_op_a[i*OW +: OW] = da[i];
      req_op_b[i*OW +: OW] = db[i];
      req_opc[i*CW +: CW]  = dc[i];
    end
  end

  // Register file the controller fronts
  always @(posedge clk) if (load_en) mem[write_pointer] <= {opcode, operand_a, operand_b};
  assign instr_word_in = mem[read_pointer];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: stored entries as {addr, word}, next write address, next priority
  logic [AW+IW-1:0] model_fifo [$];
  int               model_wp = 0;
  int               model_rr = 0;

  logic [AW+IW-1:0] wr_q [$];
  logic [AW+IW-1:0] rd_q [$];
  int               rd_cyc_q [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int model_pick(input logic [NR-1:0] mask);
    for (int i = 0; i < NR; i++)
      if (mask[(model_rr + i) % NR]) return (model_rr + i) % NR;
    return -1;
  endfunction

  task automatic model_clear();
    model_fifo.delete();
    model_wp = 0;
  endtask

  task automatic new_data(input int i);
    da[i] = $urandom;
    db[i] = $urandom;
    dc[i] = CW'($urandom);
  endtask

  // Monitor: pops expected results as the DUT presents them
  logic [AW+IW-1:0] mon_e;
  int               mon_c;
  always @(negedge clk) begin
    if (!reset) begin
      if (load_en) begin
        if (wr_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL wr_unexpected: load_en=1 with no pending write (required 0)");
        end else begin
          mon_e = wr_q.pop_front();
          chk("wr_ptr", 128'(write_pointer), 128'(mon_e[AW+IW-1:IW]));
          chk("wr_word", 128'({opcode, operand_a, operand_b}), 128'(mon_e[IW-1:0]));
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rd_unexpected: rd_valid=1 with no pending read (required 0)");
        end else begin
          mon_e = rd_q.pop_front();
          mon_c = rd_cyc_q.pop_front();
          chk("rd_data", 128'(rd_data), 128'(mon_e[IW-1:0]));
          chk("rd_ptr", 128'(read_pointer), 128'(mon_e[AW+IW-1:IW]));
          chk("rd_latency", 128'(cyc), 128'(mon_c));
        end
      end
    end
  end

  // Waits for a grant with req_valid=mask already driven; updates the model on success
  task automatic grant_wait(input logic [NR-1:0] mask, output int gcyc, output bit ok);
    int pick;
    logic [IW-1:0] w;
    ok = 1'b0;
    gcyc = -1;
    for (int t = 0; t < 8 && !ok; t++) begin
      @(negedge clk);
      if (req_ready != '0) ok = 1'b1;
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL grant_timeout: req_ready=0 for mask %b (required a grant)", mask);
      return;
    end
    pick = model_pick(mask);
    chk("grant", 128'(req_ready), 128'(1) << pick);
    gcyc = cyc;
    w = {dc[pick], da[pick], db[pick]};
    wr_q.push_back({AW'(model_wp), w});
    model_fifo.push_back({AW'(model_wp), w});
    model_wp = (model_wp + 1) % DP;
    model_rr = (pick + 1) % NR;
  endtask

  // n grants with mask held; starts and ends just after a rising edge with the DUT idle
  task automatic wr_burst(input logic [NR-1:0] mask, input int n);
    int gc, last;
    bit ok;
    last = 0;
    req_valid = mask;
    for (int k = 0; k < n; k++) begin
      grant_wait(mask, gc, ok);
      if (!ok) break;
      if (k > 0) chk("wr_cadence", 128'(gc - last), 128'(2));
      last = gc;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++) if (req_ready[i]) new_data(i);
      new_data(model_rr == 0 ? NR - 1 : model_rr - 1);
    end
    req_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic wr_op(input logic [NR-1:0] mask);
    if (model_fifo.size() == DP) begin
      req_valid = mask;
      repeat (3) begin
        @(negedge clk);
        chk("full_block", 128'(req_ready), 128'(0));
      end
      @(posedge clk); #1;
      req_valid = '0;
    end else begin
      wr_burst(mask, 1);
    end
  endtask

  task automatic rd_op();
    int c;
    c = cyc;
    rd_req = 1'b1;
    if (model_fifo.size() > 0) begin
      rd_q.push_back(model_fifo.pop_front());
      rd_cyc_q.push_back(c + 3);
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic rd_hold();
    int c, k;
    c = cyc;
    k = 0;
    rd_req = 1'b1;
    while (model_fifo.size() > 0) begin
      rd_q.push_back(model_fifo.pop_front());
      rd_cyc_q.push_back(c + 3 + 3 * k);
      k++;
    end
    repeat (3 * k + 4) @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic flush_op();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
  endtask

  task automatic chk_occ(input string nm);
    chk({nm, "_count"}, 128'(count), 128'(model_fifo.size()));
    chk({nm, "_empty"}, 128'(empty), 128'(model_fifo.size() == 0));
    chk({nm, "_full"}, 128'(full), 128'(model_fifo.size() == DP));
  endtask

  initial begin
    int gc, c, r;
    bit ok;
    for (int i = 0; i < NR; i++) new_data(i);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    chk("rst_load_en", 128'(load_en), 128'(0));
    chk("rst_req_ready", 128'(req_ready), 128'(0));
    chk("rst_rd_valid", 128'(rd_valid), 128'(0));
    chk("rst_operands", 128'({operand_a, operand_b, opcode}), 128'(0));
    chk("rst_rd_data", 128'(rd_data), 128'(0));
    chk("rst_pointers", 128'({write_pointer, read_pointer}), 128'(0));
    chk_occ("rst");

    // Single write with signed operand
    da[0] = 32'd5; db[0] = -32'sd3; dc[0] = 4'd2;
    wr_burst(4'b0001, 1);
    chk_occ("single");

    // Fairness with all requesters held
    wr_burst(4'b1111, 5);
    chk_occ("fair");

    // Readback of everything stored, rd_req held past empty
    rd_hold();
    chk_occ("readback");

    // Fill to full, blocked writes, one read, then wrapped write
    flush_op();
    for (int k = 0; k < DP; k++) wr_burst(NR'($urandom_range(1, 15)), 1);
    chk_occ("fill");
    wr_op(4'b1111);
    rd_op();
    wr_op(4'b0100);
    chk_occ("wrap");

    // Read wins over a simultaneous write request
    flush_op();
    wr_burst(4'b1111, 5);
    c = cyc;
    rd_req = 1'b1;
    req_valid = 4'b0100;
    rd_q.push_back(model_fifo.pop_front());
    rd_cyc_q.push_back(c + 3);
    @(negedge clk);
    chk("rd_priority", 128'(req_ready), 128'(0));
    @(posedge clk); #1;
    rd_req = 1'b0;
    grant_wait(4'b0100, gc, ok);
    if (ok) chk("wr_after_rd", 128'(gc), 128'(c + 3));
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk_occ("prio");

    // Flush with entries stored
    flush_op();
    chk_occ("flush");
    chk("flush_ptrs", 128'({write_pointer, read_pointer}), 128'(0));
    repeat (2) begin
      @(negedge clk);
      chk("flush_no_load", 128'(load_en), 128'(0));
    end
    @(posedge clk); #1;

    // Flush pulsed only during WR is ignored
    req_valid = 4'b0010;
    grant_wait(4'b0010, gc, ok);
    @(posedge clk); #1;
    flush = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    flush = 1'b0;
    chk_occ("flush_in_wr");

    // Asynchronous reset in the middle of WR
    req_valid = 4'b0001;
    grant_wait(4'b0001, gc, ok);
    @(posedge clk); #2;
    reset = 1'b1;
    req_valid = '0;
    #1;
    chk("rst_mid_wr_load_en", 128'(load_en), 128'(0));
    wr_q.delete();
    model_clear();
    model_rr = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_occ("rst_mid_wr");
    wr_burst(4'b1111, 1);

    // Randomised mix of writes, reads and flushes
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      wr_op(NR'($urandom_range(1, 15)));
      else if (r < 9) rd_op();
      else            flush_op();
      chk_occ("rand");
    end
    rd_hold();

    repeat (4) @(posedge clk);
    #1;
    chk("wr_q_drained", 128'(wr_q.size()), 128'(0));
    chk("rd_q_drained", 128'(rd_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instr_reg_ctrl.md
Name: instr_reg_ctrl

Overview:
Write/read controller that shares the instruction register file between NUM_REQ write requesters and one read consumer. It round-robin arbitrates write requests and drives load_en, operand_a, operand_b, opcode and write_pointer with auto-incrementing addressing. It drives read_pointer for in-order (FIFO-style) readback, captures instruction_word, and tracks occupancy. It sits between the bench or agent interfaces and the register file.

Parameters:
NUM_REQ, 4, number of write requesters (2..8)
DEPTH, 32, register file entries (2..2**ADDR_W)
ADDR_W, 5, pointer width
OP_W, 32, operand width (signed)
OPC_W, 4, opcode width
INSTR_W, 68, instruction_word width (OPC_W + 2*OP_W)

Ports:
clk  in  1  clock, rising edge
reset  in  1  async active-high reset
flush  in  1  sync clear of pointers and count
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  one-hot accept pulse
req_op_a  in  NUM_REQ*OP_W  packed operand_a, requester i at [i*OP_W +: OP_W]
req_op_b  in  NUM_REQ*OP_W  packed operand_b
req_opc  in  NUM_REQ*OPC_W  packed opcode
load_en  out  1  register file write strobe
operand_a  out  OP_W  write data
operand_b  out  OP_W  write data
opcode  out  OPC_W  write data
write_pointer  out  ADDR_W  write address
read_pointer  out  ADDR_W  read address
instr_word_in  in  INSTR_W  register file instruction_word
rd_req  in  1  level request for next stored entry
rd_valid  out  1  1-cycle pulse, rd_data valid
rd_data  out  INSTR_W  captured instruction word
count  out  ADDR_W+1  entries stored
full  out  1  count==DEPTH
empty  out  1  count==0

Behaviour:
- Reset (async, immediate): state IDLE; load_en, req_ready, rd_valid = 0; operand_a, operand_b, opcode, rd_data = 0; wr_ptr, rd_ptr, write_pointer, read_pointer, count = 0; empty = 1; full = 0; round-robin pointer set so requester 0 has top priority.
- FSM states: IDLE, WR, RD, CAP.
- IDLE priority, highest first:
  - flush: clear pointers and count; stay IDLE.
  - rd_req && !empty: drive read_pointer<=rd_ptr; go to RD.
  - any req_valid && !full: grant g = first valid requester at or after rr_ptr, wrapping. req_ready[g]=1 combinationally this cycle. Register g's data into operand_a, operand_b, opcode, and write_pointer<=wr_ptr. Set rr_ptr<=g+1 mod NUM_REQ. Go to WR.
  - otherwise: stay IDLE.
- WR (1 cycle): load_en=1. At the edge: wr_ptr++ (DEPTH-1 wraps to 0), count++; go to IDLE. Write throughput is 1 per 2 cycles.
- RD (1 cycle): read_pointer held for the register file read. Go to CAP.
- CAP: rd_data<=instr_word_in, rd_valid=1 for 1 cycle, rd_ptr++ (wrap), count--; go to IDLE. Read latency from rd_req accept to rd_valid is 2 cycles.
- req_ready is never asserted outside IDLE, when full, or for an invalid requester. At most one bit is set.
- flush is ignored outside IDLE; it takes effect on the next IDLE cycle. It never aborts an in-progress WR or CAP.
- count is never incremented and decremented in the same cycle, because the FSM serialises operations.
- Outputs hold their last value when not strobed, except load_en, req_ready and rd_valid.
- Reset asserted mid-WR drops load_en asynchronously; no commit happens.

Test Plan:
- Reset then single write: req_valid=4'b0001, op_a=5, op_b=-3, opc=2 -> req_ready[0] pulse; next cycle load_en=1, write_pointer=0, operand_a=5, operand_b=-3; count=1, empty=0.
- Fairness: req_valid=4'b1111 held -> grants in order 0,1,2,3,0, one grant every 2 cycles; write_pointer 0,1,2,3,4.
- Fill and wrap: 32 writes -> full=1, count=32, req_ready stays 0 with req_valid high. Then 1 read -> 33rd write lands at write_pointer=0.
- Readback: write 3 entries, then hold rd_req -> read_pointer 0,1,2; rd_valid 2 cycles after each accept; rd_data matches {opc, op_a, op_b}; empty=1 after the third read; rd_req then ignored.
- Read priority and flush: rd_req and req_valid both high in IDLE -> read first. flush with count=5 -> count=0, pointers 0, no load_en.
- Async reset during WR: assert reset mid-cycle -> load_en=0 immediately; count unchanged at 0 after release.
